// File: rtl/uart_rx_ext.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uart_rx_ext
//
// Parametrised UART receiver. Runtime data length (5..MAX_DATA_BITS), internal
// sample-tick divider, 2-flop input synchroniser, false-start rejection,
// 3-sample majority voting, optional parity, one or two checked stop bits and
// a valid/ready output handshake with overrun detection.
//
// Optional feature macro: UART_RX_BREAK_EN
//   Defined   : adds break_det and a BREAK_WAIT state; an all-zero frame with a
//               low stop bit (and a zero parity bit when enabled) is reported
//               as a one-clock break_det pulse instead of data.
//   Undefined : such a frame is delivered as data=0 with frame_err=1.
//
// Ports
//   clk            clock
//   rst            asynchronous reset, active low
//   ena            enable; tick divider, sample counter and FSM hold when low
//   baud_rate_div  one sample tick every baud_rate_div+1 clocks
//   data_len       data bits per frame, clamped to 5..MAX_DATA_BITS
//   parity_ena     parity bit present
//   parity_type    0 = even, 1 = odd
//   stop_size      0 = one stop bit, 1 = two stop bits
//   rx             asynchronous serial input
//   data           received word, LSB aligned, unused upper bits 0
//   valid          data and error flags are valid
//   ready          consumer accepts the word while valid=1
//   parity_err     parity mismatch for the presented word
//   frame_err      a stop bit was sampled low for the presented word
//   overrun        a frame was dropped because the previous word was unread
//   break_det      (UART_RX_BREAK_EN only) one-clock pulse on a break
//   busy           receiver FSM is not idle
// -----------------------------------------------------------------------------
module uart_rx_ext #(
  parameter int MAX_DATA_BITS = 9,
  parameter int OVERSAMPLE    = 16,
  parameter int BAUD_DIV_BITS = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ena,
  input  logic [BAUD_DIV_BITS-1:0] baud_rate_div,
  input  logic [3:0]               data_len,
  input  logic                     parity_ena,
  input  logic                     parity_type,
  input  logic                     stop_size,
  input  logic                     rx,
  output logic [MAX_DATA_BITS-1:0] data,
  output logic                     valid,
  input  logic                     ready,
  output logic                     parity_err,
  output logic                     frame_err,
  output logic                     overrun,
`ifdef UART_RX_BREAK_EN
  output logic                     break_det,
`endif
  output logic                     busy
);

  localparam int SC_W = $clog2(OVERSAMPLE);
  localparam int MID  = OVERSAMPLE / 2;

  localparam logic [SC_W-1:0] SC_MID_M1 = SC_W'(MID - 1);
  localparam logic [SC_W-1:0] SC_MID    = SC_W'(MID);
  localparam logic [SC_W-1:0] SC_MID_P1 = SC_W'(MID + 1);
  localparam logic [SC_W-1:0] SC_LAST   = SC_W'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP1,
    S_STOP2
`ifdef UART_RX_BREAK_EN
    , S_BREAK_WAIT
`endif
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Input synchroniser
  logic r_rx_meta;
  logic r_rxs;

  // Tick divider and sample counter
  logic [BAUD_DIV_BITS-1:0] r_tick_cnt;
  logic                     w_tick_hit;
  logic                     w_tick;
  logic [SC_W-1:0]          r_sc;
  logic [1:0]               r_maj;
  logic                     w_maj;

  // Per-frame configuration, latched at the start edge
  logic [3:0] w_len_clamped;
  logic [3:0] r_len;
  logic       r_par_ena;
  logic       r_par_type;
  logic       r_two_stop;

  // Frame assembly
  logic [3:0]               r_bit_cnt;
  logic [MAX_DATA_BITS-1:0] r_shift;
  logic                     r_par_acc;
  logic                     r_perr;
  logic                     r_ferr;
  logic                     w_ferr_final;
`ifdef UART_RX_BREAK_EN
  logic                     r_par_bit;
  logic                     w_is_break;
  logic                     r_break_det;
`endif

  // FSM strobes
  logic w_frame_start;
  logic w_data_smp;
  logic w_par_smp;
  logic w_stop_smp;
  logic w_done;
  logic w_break;

  // Output registers
  logic [MAX_DATA_BITS-1:0] r_data;
  logic                     r_valid;
  logic                     r_parity_err;
  logic                     r_frame_err;
  logic                     r_overrun;

  // ---------------------------------------------------------------------------
  // Synchroniser: idles high so reset never looks like a start edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of its neighbours.
    if (!rst) begin
      r_rx_meta <= 1'b1;
      r_rxs     <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rxs     <= r_rx_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Sample-tick divider. The >= compare keeps the counter from running the
  // full range if baud_rate_div is lowered below the current count.
  // ---------------------------------------------------------------------------
  assign w_tick_hit = (r_tick_cnt >= baud_rate_div);
  assign w_tick     = ena && w_tick_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tick_cnt <= '0;
    end else if (ena) begin
      r_tick_cnt <= w_tick_hit ? '0 : r_tick_cnt + BAUD_DIV_BITS'(1);
    end
  end

  // Majority of the samples at M-1, M (stored) and M+1 (live).
  assign w_maj = (r_maj[0] & r_maj[1]) | (r_maj[0] & r_rxs) | (r_maj[1] & r_rxs);

  always_comb begin
    w_len_clamped = data_len;
    if (data_len < 4'd5) begin
      w_len_clamped = 4'd5;
    end else if (data_len > 4'(MAX_DATA_BITS)) begin
      w_len_clamped = 4'(MAX_DATA_BITS);
    end
  end

  // Stop-bit result including the sample taken in the completing cycle.
  assign w_ferr_final = r_ferr | ~w_maj;

`ifdef UART_RX_BREAK_EN
  assign w_is_break = w_ferr_final && (r_shift == '0) && !r_par_bit;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and strobes. Everything advances only on a sample tick.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    w_state_next  = r_state;
    w_frame_start = 1'b0;
    w_data_smp    = 1'b0;
    w_par_smp     = 1'b0;
    w_stop_smp    = 1'b0;
    w_done        = 1'b0;
    w_break       = 1'b0;

    if (w_tick) begin
      case (r_state)
        S_IDLE: begin
          if (!r_rxs) begin
            w_state_next  = S_START;
            w_frame_start = 1'b1;
          end
        end
        S_START: begin
          // A start bit that reads high at its centre was a glitch.
          if ((r_sc == SC_MID_P1) && w_maj) begin
            w_state_next = S_IDLE;
          end else if (r_sc == SC_LAST) begin
            w_state_next = S_DATA;
          end
        end
        S_DATA: begin
          w_data_smp = (r_sc == SC_MID_P1);
          // r_bit_cnt reaches r_len after the final data sample.
          if ((r_sc == SC_LAST) && (r_bit_cnt == r_len)) begin
            w_state_next = r_par_ena ? S_PARITY : S_STOP1;
          end
        end
        S_PARITY: begin
          w_par_smp = (r_sc == SC_MID_P1);
          if (r_sc == SC_LAST) begin
            w_state_next = S_STOP1;
          end
        end
        S_STOP1: begin
          if (r_sc == SC_MID_P1) begin
            w_stop_smp = 1'b1;
            if (!r_two_stop) begin
              w_done       = 1'b1;
              w_state_next = S_IDLE;
            end
          end else if (r_sc == SC_LAST) begin
            w_state_next = S_STOP2;
          end
        end
        S_STOP2: begin
          if (r_sc == SC_MID_P1) begin
            w_stop_smp   = 1'b1;
            w_done       = 1'b1;
            w_state_next = S_IDLE;
          end
        end
`ifdef UART_RX_BREAK_EN
        S_BREAK_WAIT: begin
          if (r_rxs) begin
            w_state_next = S_IDLE;
          end
        end
`endif
        default: w_state_next = S_IDLE;
      endcase

`ifdef UART_RX_BREAK_EN
      if (w_done && w_is_break) begin
        w_break      = 1'b1;
        w_state_next = S_BREAK_WAIT;
      end
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Sample counter and frame assembly
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sc       <= '0;
      r_maj      <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_par_acc  <= 1'b0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
      r_len      <= 4'd5;
      r_par_ena  <= 1'b0;
      r_par_type <= 1'b0;
      r_two_stop <= 1'b0;
`ifdef UART_RX_BREAK_EN
      r_par_bit  <= 1'b0;
`endif
    end else if (w_tick) begin
      if (w_frame_start) begin
        r_sc       <= '0;
        r_bit_cnt  <= '0;
        r_shift    <= '0;
        r_par_acc  <= 1'b0;
        r_perr     <= 1'b0;
        r_ferr     <= 1'b0;
        r_len      <= w_len_clamped;
        r_par_ena  <= parity_ena;
        r_par_type <= parity_type;
        r_two_stop <= stop_size;
`ifdef UART_RX_BREAK_EN
        r_par_bit  <= 1'b0;
`endif
      end else begin
        // OVERSAMPLE is a power of two, so the increment wraps on its own.
        r_sc <= r_sc + SC_W'(1);
        if (r_sc == SC_MID_M1) begin
          r_maj[0] <= r_rxs;
        end
        if (r_sc == SC_MID) begin
          r_maj[1] <= r_rxs;
        end
        if (w_data_smp) begin
          // Bits land at their own index, keeping the word LSB aligned with
          // zeros above the configured length.
          r_shift[r_bit_cnt] <= w_maj;
          r_par_acc          <= r_par_acc ^ w_maj;
          r_bit_cnt          <= r_bit_cnt + 4'd1;
        end
        if (w_par_smp) begin
          r_perr <= (w_maj != (r_par_acc ^ r_par_type));
`ifdef UART_RX_BREAK_EN
          r_par_bit <= w_maj;
`endif
        end
        if (w_stop_smp) begin
          r_ferr <= w_ferr_final;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output word and handshake
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
    end else if (w_done && !w_break) begin
      if (!r_valid || ready) begin
        r_data       <= r_shift;
        r_parity_err <= r_perr;
        r_frame_err  <= w_ferr_final;
        r_valid      <= 1'b1;
      end else begin
        // Old word still unread: keep it and flag the loss.
        r_overrun <= 1'b1;
      end
    end else if (r_valid && ready) begin
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end
  end

`ifdef UART_RX_BREAK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_break_det <= 1'b0;
    end else begin
      r_break_det <= w_break;
    end
  end

  assign break_det = r_break_det;
`endif

  assign data       = r_data;
  assign valid      = r_valid;
  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;
  assign overrun    = r_overrun;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_ext.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_uart_rx_ext
//
// Directed frames are driven on rx at negedges. A frame-level model predicts
// each delivered word (masked data, parity and stop results, break handling,
// acceptance against the handshake) and queues it; a compare process checks
// the DUT word on every cycle valid is high. Literal expectations pin the
// model for the individual scenarios.
// -----------------------------------------------------------------------------
module tb_uart_rx_ext;

  localparam int MAXB = 9;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            ena = 1'b1;
  logic [15:0]     baud_rate_div = 16'd3;
  logic [3:0]      data_len = 4'd8;
  logic            parity_ena = 1'b0;
  logic            parity_type = 1'b0;
  logic            stop_size = 1'b0;
  logic            rx = 1'b1;
  logic            ready = 1'b1;
  logic [MAXB-1:0] data;
  logic            valid;
  logic            parity_err;
  logic            frame_err;
  logic            overrun;
  logic            busy;
`ifdef UART_RX_BREAK_EN
  logic            break_det;
`endif

  always #5 clk = ~clk;

  uart_rx_ext #(
    .MAX_DATA_BITS(MAXB),
    .OVERSAMPLE   (16),
    .BAUD_DIV_BITS(16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ena          (ena),
    .baud_rate_div(baud_rate_div),
    .data_len     (data_len),
    .parity_ena   (parity_ena),
    .parity_type  (parity_type),
    .stop_size    (stop_size),
    .rx           (rx),
    .data         (data),
    .valid        (valid),
    .ready        (ready),
    .parity_err   (parity_err),
    .frame_err    (frame_err),
    .overrun      (overrun),
`ifdef UART_RX_BREAK_EN
    .break_det    (break_det),
`endif
    .busy         (busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Frame-level model
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [MAXB-1:0] data;
    logic            perr;
    logic            ferr;
  } exp_t;

  exp_t exp_q[$];
  logic model_pending = 1'b0;
  logic model_overrun = 1'b0;
  int   exp_breaks    = 0;

  function automatic int clamp_len(input logic [3:0] l);
    if (int'(l) < 5)    return 5;
    if (int'(l) > MAXB) return MAXB;
    return int'(l);
  endfunction

  function automatic int bit_clks();
    return (int'(baud_rate_div) + 1) * 16;
  endfunction

  task automatic model_frame(input logic [MAXB-1:0] d, input logic pbit,
                             input logic s1, input logic s2);
    int   n;
    exp_t e;
    logic brk;
    n      = clamp_len(data_len);
    e.data = d & MAXB'((1 << n) - 1);
    e.perr = parity_ena ? (pbit != ((^e.data) ^ parity_type)) : 1'b0;
    e.ferr = !s1 || (stop_size && !s2);
    brk    = 1'b0;
`ifdef UART_RX_BREAK_EN
    brk = e.ferr && (e.data == '0) && (!parity_ena || !pbit);
`endif
    if (brk) begin
      exp_breaks++;
    end else if (model_pending) begin
      model_overrun = 1'b1;
    end else begin
      exp_q.push_back(e);
      if (!ready) model_pending = 1'b1;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Wire driver (uses the current configuration inputs)
  // ---------------------------------------------------------------------------
  task automatic drive_bit(input logic b);
    rx = b;
    repeat (bit_clks()) @(negedge clk);
  endtask

  task automatic tx_frame(input logic [MAXB-1:0] d, input logic pbit,
                          input logic s1, input logic s2);
    int n;
    n = clamp_len(data_len);
    drive_bit(1'b0);
    for (int i = 0; i < n; i++) drive_bit(d[i]);
    if (parity_ena) drive_bit(pbit);
    drive_bit(s1);
    if (stop_size) drive_bit(s2);
    drive_bit(1'b1);
  endtask

  task automatic frame(input logic [MAXB-1:0] d, input logic pbit,
                       input logic s1, input logic s2);
    model_frame(d, pbit, s1, s2);
    tx_frame(d, pbit, s1, s2);
  endtask

  // ---------------------------------------------------------------------------
  // Compare process
  // ---------------------------------------------------------------------------
  logic            prev_valid = 1'b0;
  logic            have_cur   = 1'b0;
  exp_t            cur;
  logic [MAXB-1:0] last_data  = '0;
  logic            last_perr  = 1'b0;
  logic            last_ferr  = 1'b0;
  int              break_cycles = 0;

  always @(negedge clk) begin
    if (rst) begin
      if (valid && !prev_valid) begin
        check("valid_has_model_word", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          cur      = exp_q.pop_front();
          have_cur = 1'b1;
        end
        last_data = data;
        last_perr = parity_err;
        last_ferr = frame_err;
      end
      if (valid && have_cur) begin
        check("cmp_data", 32'(data), 32'(cur.data));
        check("cmp_parity_err", 32'(parity_err), 32'(cur.perr));
        check("cmp_frame_err", 32'(frame_err), 32'(cur.ferr));
      end
`ifdef UART_RX_BREAK_EN
      if (break_det) break_cycles++;
`endif
    end
    prev_valid = valid;
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  initial begin
    bit seen_busy;

    repeat (3) @(negedge clk);
    check("reset_data", 32'(data), 32'd0);
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_flags", {29'd0, parity_err, frame_err, overrun}, 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    repeat (10) @(negedge clk);

    // 1: 8N1, 0xA5
    frame(9'h0A5, 1'b0, 1'b1, 1'b1);
    check("s1_delivered", 32'(exp_q.size()), 32'd0);
    check("s1_data", 32'(last_data), 32'h0A5);
    check("s1_flags", {30'd0, last_perr, last_ferr}, 32'd0);

    // 2: 7E1, 0x41 with wrong then right parity bit
    data_len = 4'd7; parity_ena = 1'b1; parity_type = 1'b0;
    frame(9'h041, 1'b1, 1'b1, 1'b1);
    check("s2a_data", 32'(last_data), 32'h041);
    check("s2a_perr", 32'(last_perr), 32'd1);
    frame(9'h041, 1'b0, 1'b1, 1'b1);
    check("s2b_perr", 32'(last_perr), 32'd0);

    // 3: 9N2, second stop bit low, then both high
    data_len = 4'd9; parity_ena = 1'b0; stop_size = 1'b1;
    frame(9'h1FF, 1'b0, 1'b1, 1'b0);
    check("s3a_data", 32'(last_data), 32'h1FF);
    check("s3a_ferr", 32'(last_ferr), 32'd1);
    frame(9'h1FF, 1'b0, 1'b1, 1'b1);
    check("s3b_ferr", 32'(last_ferr), 32'd0);
    stop_size = 1'b0;

    // Length clamping: 2 -> 5 bits, 15 -> 9 bits
    data_len = 4'd2;
    frame(9'h1F5, 1'b0, 1'b1, 1'b1);
    check("clamp_lo_data", 32'(last_data), 32'h015);
    data_len = 4'd15;
    frame(9'h155, 1'b0, 1'b1, 1'b1);
    check("clamp_hi_data", 32'(last_data), 32'h155);

    // Tick every clock
    data_len = 4'd8; baud_rate_div = 16'd0;
    repeat (4) @(negedge clk);
    frame(9'h05A, 1'b0, 1'b1, 1'b1);
    check("div0_data", 32'(last_data), 32'h05A);
    baud_rate_div = 16'd3;
    repeat (8) @(negedge clk);

    // 4: 16-clock glitch is a false start
    seen_busy = 1'b0;
    rx = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (busy) seen_busy = 1'b1;
    end
    rx = 1'b1;
    check("s4_busy_rose", 32'(seen_busy), 32'd1);
    for (int i = 0; i < bit_clks() && busy; i++) @(negedge clk);
    check("s4_busy_fell", 32'(busy), 32'd0);
    repeat (bit_clks()) @(negedge clk);
    check("s4_no_valid", 32'(valid), 32'd0);

    // 5: overrun with ready low
    ready = 1'b0;
    frame(9'h011, 1'b0, 1'b1, 1'b1);
    frame(9'h022, 1'b0, 1'b1, 1'b1);
    check("s5_valid", 32'(valid), 32'd1);
    check("s5_data", 32'(data), 32'h011);
    check("s5_overrun_model", 32'(overrun), 32'(model_overrun));
    check("s5_overrun", 32'(overrun), 32'd1);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    model_pending = 1'b0;
    model_overrun = 1'b0;
    check("s5_valid_clr", 32'(valid), 32'd0);
    check("s5_overrun_clr", 32'(overrun), 32'd0);
    check("s5_data_hold", 32'(data), 32'h011);
    ready = 1'b1;
    repeat (4) @(negedge clk);

    // 6: reset pulse during data bit 3 of an 0xFF frame
    fork
      tx_frame(9'h0FF, 1'b0, 1'b1, 1'b1);
      begin
        repeat (4 * bit_clks() + bit_clks() / 2) @(negedge clk);
        check("s6_busy_before", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        check("s6_rst_data", 32'(data), 32'd0);
        check("s6_rst_outs", {28'd0, valid, parity_err, frame_err, overrun}, 32'd0);
        check("s6_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b1;
      end
    join
    frame(9'h03C, 1'b0, 1'b1, 1'b1);
    check("s6_data", 32'(last_data), 32'h03C);
    check("s6_delivered", 32'(exp_q.size()), 32'd0);

    // All-zero frame with a low stop bit
    frame(9'h000, 1'b0, 1'b0, 1'b1);
    repeat (bit_clks()) @(negedge clk);
`ifdef UART_RX_BREAK_EN
    check("brk_frame_pulses", 32'(break_cycles), 32'(exp_breaks));
    check("brk_frame_no_valid", 32'(valid), 32'd0);
    // Long break: 12 bit times low
    rx = 1'b0;
    repeat (11 * bit_clks() + bit_clks() / 2) @(negedge clk);
    check("brk_busy_held", 32'(busy), 32'd1);
    check("brk_no_valid", 32'(valid), 32'd0);
    exp_breaks++;
    check("brk_one_pulse", 32'(break_cycles), 32'(exp_breaks));
    check("brk_one_pulse_lit", 32'(break_cycles), 32'd2);
    repeat (bit_clks() / 2) @(negedge clk);
    rx = 1'b1;
    repeat (bit_clks()) @(negedge clk);
    check("brk_busy_released", 32'(busy), 32'd0);
`else
    check("zero_frame_data", 32'(last_data), 32'h000);
    check("zero_frame_ferr", 32'(last_ferr), 32'd1);
    check("zero_frame_busy_idle", 32'(busy), 32'd0);
`endif

    check("all_delivered", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
